bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 135 +++++++++++++
 tb/tb_bram_stream_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Reads a run of BRAM words and emits them as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_REM_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   c_REM_ZERO = '0;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [0:1];
  logic [1:0]            r_fifo_last;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_last_pop;
  logic [2:0]            w_occ;

  assign m_tvalid   = (r_count != 2'd0);
  assign m_tdata    = r_fifo_data[r_rd_ptr];
  assign m_tlast    = m_tvalid && r_fifo_last[r_rd_ptr];
  assign bram_raddr = r_addr;
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = (r_state == S_IDLE) && !r_done;
    busy         = (r_state != S_IDLE);
    w_accept     = cmd_valid && cmd_ready;
    w_pop        = m_tvalid && m_tready;
    w_last_pop   = w_pop && m_tlast;
    // Occupancy after this cycle's pop; a read is only issued if its word will fit.
    w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_issue      = (r_state == S_READ) && (r_remaining != c_REM_ZERO) && (w_occ < 3'd2);
    w_issue_last = w_issue && (r_remaining == c_REM_ONE);
    bram_re      = w_issue;

    case (r_state)
      S_IDLE:  if (w_accept && (cmd_len != c_REM_ZERO)) w_state_next = S_READ;
      S_READ:  if (w_issue_last) w_state_next = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= 2'b00;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
    end else begin
      r_done <= (w_accept && (cmd_len == c_REM_ZERO)) ||
                ((r_state == S_DRAIN) && w_last_pop);

      if (w_accept) begin
        r_addr      <= cmd_addr;
        r_remaining <= cmd_len;
      end else if (w_issue) begin
        r_addr      <= r_addr + c_ADDR_ONE;
        r_remaining <= r_remaining - c_REM_ONE;
      end

      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;

      // BRAM data is valid exactly one cycle after the read enable.
      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= bram_rdata;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bram_stream_reader
// Description : Directed self-checking bench for bram_stream_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_stream_reader;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [DW-1:0] bram_rdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [0:255];

  int            n_checks = 0;
  int            n_errors = 0;

  int            rd_q[$];
  logic [DW-1:0] bd_q[$];
  bit            bl_q[$];
  int            bc_q[$];
  int            done_n;
  int            done_c;
  int            stall_bad;
  int            max_ahead;

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .bram_re    (bram_re),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Registered-read BRAM model
  always @(posedge clk) begin
    if (bram_re) bram_rdata <= mem[bram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_bram_re"}, bram_re, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bram_raddr"}, 32'(bram_raddr), 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
  endtask

  // mode 0: m_tready held high; mode 1: m_tready high one cycle in three.
  task automatic run_cmd(input int addr, input int len, input int mode, input bit ign,
                         input int abort_at, input int max_cyc);
    bit            prev_stall;
    logic [DW-1:0] pd;
    logic          pl;
    rd_q.delete(); bd_q.delete(); bl_q.delete(); bc_q.delete();
    done_n = 0; done_c = -1; stall_bad = 0; max_ahead = 0;
    prev_stall = 0; pd = '0; pl = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = AW'(addr);
    cmd_len   = (AW+1)'(len);
    m_tready  = (mode == 0);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      cmd_valid = ign && (c == 2);
      cmd_addr  = 8'd50;
      cmd_len   = 9'd3;
      m_tready  = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (ign && c == 2) check("cmd_ready_while_busy", cmd_ready, 0);
      if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl)) stall_bad++;
      prev_stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      if (bram_re) rd_q.push_back(int'(bram_raddr));
      if (m_tvalid && m_tready) begin
        bd_q.push_back(m_tdata);
        bl_q.push_back(m_tlast);
        bc_q.push_back(c);
      end
      if (rd_q.size() - bd_q.size() > max_ahead) max_ahead = rd_q.size() - bd_q.size();
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (abort_at > 0 && bd_q.size() == abort_at) return;
      if (done_c >= 0 && c > done_c) begin
        check("cmd_ready_after_done", cmd_ready, 1);
        return;
      end
    end
    check("cmd_timeout", (done_c >= 0), 1);
  endtask

  task automatic check_run(input string tag, input int addr, input int len, input int first_c);
    check({tag, "_nreads"}, rd_q.size(), len);
    check({tag, "_nbeats"}, bd_q.size(), len);
    for (int i = 0; i < len && i < rd_q.size() && i < bd_q.size(); i++) begin
      check($sformatf("%s_raddr%0d", tag, i), rd_q[i], (addr + i) % 256);
      check($sformatf("%s_data%0d", tag, i), bd_q[i], ((addr + i) % 256) + 100);
      check($sformatf("%s_last%0d", tag, i), bl_q[i], (i == len - 1));
      if (first_c >= 0) check($sformatf("%s_cyc%0d", tag, i), bc_q[i], first_c + i);
    end
    check({tag, "_done_n"}, done_n, 1);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i + 100);

    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Basic run, plus a command attempt while busy that must be ignored
    run_cmd(4, 4, 0, 1'b1, 0, 40);
    check_run("basic", 4, 4, 3);
    check("basic_done_cycle", done_c, 7);

    // Address wrap
    run_cmd(254, 4, 0, 1'b0, 0, 40);
    check_run("wrap", 254, 4, 3);
    check("wrap_done_cycle", done_c, 7);

    // Back-pressure
    run_cmd(10, 4, 1, 1'b0, 0, 60);
    check_run("stall", 10, 4, -1);
    check("stall_stable", stall_bad, 0);
    check("stall_ahead_le2", (max_ahead <= 2), 1);

    // Zero-length command
    run_cmd(30, 0, 0, 1'b0, 0, 10);
    check("zero_nreads", rd_q.size(), 0);
    check("zero_nbeats", bd_q.size(), 0);
    check("zero_done_cycle", done_c, 1);
    check("zero_done_n", done_n, 1);

    // Reset in the middle of a command
    run_cmd(20, 8, 0, 1'b0, 2, 40);
    check("abort_beats_before", bd_q.size(), 2);
    @(posedge clk); #1;
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    check_reset("abort");
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_tvalid || done || bram_re || busy) bad++;
    end
    check("abort_quiet", bad, 0);
    run_cmd(0, 2, 0, 1'b0, 0, 20);
    check_run("after_abort", 0, 2, 3);

    // Full-depth command
    run_cmd(0, 256, 0, 1'b0, 0, 300);
    check_run("full", 0, 256, 3);
    check("full_done_cycle", done_c, 259);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
